// File: rtl/fixed_point_pkg.sv
// Shared fixed-point format parameters and the divider state encoding.
package fixed_point_pkg;

  localparam int unsigned N_FRAC = 16;
  localparam int unsigned N_INT  = 22;
  localparam int unsigned W      = 2 * (N_FRAC + N_INT) + 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/fixed_divide_seq_if.sv
// Request/result bundle of the sequential fixed-point divider.
interface fixed_divide_seq_if #(
  parameter int unsigned W = fixed_point_pkg::W
) ();

  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic         div_by_zero;
  logic         overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, div_by_zero, overflow
  );

endinterface

// File: rtl/fp_abs.sv
// Combinational two's-complement magnitude and sign; -2^(W-1) maps to the unsigned value 2^(W-1).
module fp_abs #(
  parameter int unsigned W = fixed_point_pkg::W
) (
  input  logic [W-1:0] val_i,
  output logic [W-1:0] mag_c_o,
  output logic         neg_c_o
);

  assign neg_c_o = val_i[W-1];
  assign mag_c_o = neg_c_o ? W'(~val_i + W'(1)) : val_i;

endmodule

// File: rtl/fixed_divide_seq.sv
// Sequential signed fixed-point divider: quotient = trunc((dividend << N_FRAC) / divisor),
// one restoring shift-subtract step per cycle over W+N_FRAC quotient bits.
module fixed_divide_seq #(
  parameter int unsigned N_FRAC = fixed_point_pkg::N_FRAC,
  parameter int unsigned N_INT  = fixed_point_pkg::N_INT,
  parameter int unsigned W      = 2 * (N_FRAC + N_INT) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  fixed_divide_seq_if.slave  bus
);

  localparam int unsigned WN = W + N_FRAC;
  localparam int unsigned CW = $clog2(WN + 1);

  fixed_point_pkg::div_state_e state_q, state_d;

  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [W-1:0]  den_q, den_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [WN-1:0] num_q, num_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_q, neg_d, dz_q, dz_d;
  logic [W-1:0]  quot_q, quot_d;
  logic          ovf_q, ovf_d, dzo_q, dzo_d;
  logic          busy_q, busy_d, done_q, done_d;

  logic [W-1:0]  mag_a, mag_b;
  logic          neg_a, neg_b;
  logic [W:0]    rem_sh, trial;
  logic [WN-1:0] lim;
  logic [W-1:0]  q_low;

  fp_abs #(.W(W)) u_abs_a (.val_i(a_q), .mag_c_o(mag_a), .neg_c_o(neg_a));
  fp_abs #(.W(W)) u_abs_b (.val_i(b_q), .mag_c_o(mag_b), .neg_c_o(neg_b));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= fixed_point_pkg::ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      den_q   <= '0;
      rem_q   <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      ovf_q   <= 1'b0;
      dzo_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      den_q   <= den_d;
      rem_q   <= rem_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      ovf_q   <= ovf_d;
      dzo_q   <= dzo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    den_d   = den_q;
    rem_d   = rem_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    ovf_d   = ovf_q;
    dzo_d   = dzo_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    // Remainder stays below the divisor, so W bits hold it; the trial needs one more.
    rem_sh = {rem_q, num_q[WN-1]};
    trial  = rem_sh - {1'b0, den_q};
    // Largest representable magnitude: 2^(W-1) when negative, 2^(W-1)-1 when positive.
    lim    = (WN'(1) << (W - 1)) - WN'(!neg_q);
    q_low  = num_q[W-1:0];

    unique case (state_q)
      fixed_point_pkg::ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.dividend;
          b_d     = bus.divisor;
          state_d = fixed_point_pkg::ST_PREP;
        end
      end
      fixed_point_pkg::ST_PREP: begin
        num_d   = {mag_a, {N_FRAC{1'b0}}};
        den_d   = mag_b;
        rem_d   = '0;
        neg_d   = neg_a ^ neg_b;
        dz_d    = (mag_b == '0);
        cnt_d   = CW'(WN);
        state_d = fixed_point_pkg::ST_DIV;
      end
      fixed_point_pkg::ST_DIV: begin
        if (!trial[W]) begin
          rem_d = trial[W-1:0];
          num_d = {num_q[WN-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[W-1:0];
          num_d = {num_q[WN-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = fixed_point_pkg::ST_FIX;
      end
      fixed_point_pkg::ST_FIX: begin
        if (dz_q) begin
          quot_d = '0;
          ovf_d  = 1'b0;
          dzo_d  = 1'b1;
        end else begin
          quot_d = neg_q ? W'(~q_low + W'(1)) : q_low;
          ovf_d  = (num_q > lim);
          dzo_d  = 1'b0;
        end
        state_d = fixed_point_pkg::ST_DONE;
      end
      fixed_point_pkg::ST_DONE: state_d = fixed_point_pkg::ST_IDLE;
      default:                  state_d = fixed_point_pkg::ST_IDLE;
    endcase

    busy_d = (state_d != fixed_point_pkg::ST_IDLE);
    done_d = (state_d == fixed_point_pkg::ST_DONE);
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.div_by_zero = dzo_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_fixed_divide_seq.sv
// Bench for fixed_divide_seq: wide-integer reference model checked every cycle plus literal results.
module tb_fixed_divide_seq;

  localparam int unsigned W  = 77;
  localparam int unsigned RW = W + 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fixed_divide_seq_if #(.W(W)) bus ();

  fixed_divide_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {overflow, div_by_zero, quotient} from plain signed arithmetic.
  function automatic logic [RW-1:0] model_div(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [127:0] n, d, q, lim_p, lim_n;
    logic ov;
    if (b == '0) return {1'b0, 1'b1, {W{1'b0}}};
    n     = {{(128-W){a[W-1]}}, a};
    d     = {{(128-W){b[W-1]}}, b};
    n     = n <<< 16;
    q     = n / d;
    lim_p = (128'sd1 <<< (W - 1)) - 128'sd1;
    lim_n = -(128'sd1 <<< (W - 1));
    ov    = (q > lim_p) || (q < lim_n);
    return {ov, 1'b0, q[W-1:0]};
  endfunction

  // Transaction-level model: latency counter since acceptance and the held result.
  bit             live    = 1'b0;
  bit             m_busy  = 1'b0;
  bit             h_valid = 1'b0;
  int             k       = 0;
  logic [RW-1:0]  pend    = '0;
  logic [RW-1:0]  held    = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      live = 1'b1; m_busy = 1'b0; k = 0; held = '0; h_valid = 1'b1;
    end else if (!m_busy) begin
      if (bus.start === 1'b1) begin
        m_busy  = 1'b1;
        k       = 0;
        pend    = model_div(bus.dividend, bus.divisor);
        h_valid = 1'b0;
      end
    end else begin
      k++;
      if (k == 95) begin held = pend; h_valid = 1'b1; end
      if (k == 96) m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("busy", 128'(bus.busy), 128'(m_busy));
      chk("done", 128'(bus.done), 128'(m_busy && k == 95));
      if (h_valid) begin
        chk("quotient",    128'(bus.quotient),    128'(held[W-1:0]));
        chk("div_by_zero", 128'(bus.div_by_zero), 128'(held[W]));
        chk("overflow",    128'(bus.overflow),    128'(held[W+1]));
      end
    end
  end

  task automatic run(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] exp_q, input logic exp_ovf, input logic exp_dz);
    int lat;
    bit seen;
    chk({name, "/model"}, 128'(model_div(a, b)), 128'({exp_ovf, exp_dz, exp_q}));
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(negedge clk);
    bus.start = 1'b0; bus.dividend = ~a; bus.divisor = b ^ 77'h5A5A5;
    lat = 1; seen = 1'b0;
    while (!seen && lat < 200) begin
      if (bus.done === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk({name, "/latency"}, 128'(seen ? lat : 0), 128'(96));
    if (seen) begin
      chk({name, "/q"},   128'(bus.quotient),    128'(exp_q));
      chk({name, "/ovf"}, 128'(bus.overflow),    128'(exp_ovf));
      chk({name, "/dz"},  128'(bus.div_by_zero), 128'(exp_dz));
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst/busy", 128'(bus.busy), 128'(0));
    chk("rst/done", 128'(bus.done), 128'(0));
    chk("rst/q",    128'(bus.quotient), 128'(0));
    chk("rst/flags", 128'({bus.overflow, bus.div_by_zero}), 128'(0));
    rst_n = 1'b1;

    run("six_by_two", 77'h60000, 77'h20000, 77'h30000, 1'b0, 1'b0);
    run("neg_half",   -77'sh18000, 77'h8000, -77'sh30000, 1'b0, 1'b0);
    run("third",      77'h10000, 77'h30000, 77'h5555, 1'b0, 1'b0);
    run("neg_third",  -77'sh10000, 77'h30000, -77'sh5555, 1'b0, 1'b0);
    run("div_zero",   77'h10000, 77'h0, 77'h0, 1'b0, 1'b1);
    run("ovf_wrap",   77'd1 << 75, 77'd1, 77'h0, 1'b1, 1'b0);
    run("min_by_one", 77'd1 << 76, 77'h10000, 77'd1 << 76, 1'b0, 1'b0);
    run("min_by_m1",  77'd1 << 76, -77'sh10000, 77'd1 << 76, 1'b1, 1'b0);
    run("max_by_one", (77'd1 << 76) - 77'd1, 77'h10000, (77'd1 << 76) - 77'd1, 1'b0, 1'b0);
    run("seven_m3",   77'd7, -77'sd3, -77'sd152917, 1'b0, 1'b0);

    // Restart attempt while busy, then reset at cycle 40 abandons the division.
    dcount = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 77'h60000; bus.divisor = 77'h20000;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c < 40; c++) begin
      if (c == 10) begin bus.start = 1'b1; bus.dividend = 77'h10000; bus.divisor = 77'h0; end
      if (c == 11) bus.start = 1'b0;
      if (bus.done === 1'b1) dcount++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort/busy", 128'(bus.busy), 128'(0));
    chk("abort/q",    128'(bus.quotient), 128'(0));
    chk("abort/flags", 128'({bus.overflow, bus.div_by_zero}), 128'(0));
    repeat (110) begin
      if (bus.done === 1'b1) dcount++;
      @(negedge clk);
    end
    chk("abort/no_done", 128'(dcount), 128'(0));

    run("after_abort", 77'h60000, 77'h20000, 77'h30000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
